// File: rtl/draw_grid_image_if.sv
// draw_grid_image_if: pixel request, RAM read and RGB result signals of the grid renderer
interface draw_grid_image_if #(parameter int ADDR_W = 18);
  logic reload;
  logic [9:0] x, y;
  logic hl_en;
  logic [2:0] hl_cx, hl_cy;
  logic [7:0] q;
  logic [ADDR_W-1:0] rdaddress;
  logic ready, hdr_err;
  logic [7:0] red, green, blue;
  modport master (output reload, x, y, hl_en, hl_cx, hl_cy, q, input rdaddress, ready, hdr_err, red, green, blue);
  modport slave (input reload, x, y, hl_en, hl_cx, hl_cy, q, output rdaddress, ready, hdr_err, red, green, blue);
endinterface

// File: rtl/draw_grid_image.sv
// draw_grid_image: loads image size from a RAM header, then renders the grayscale image
// with a GRID_N x GRID_N line overlay and an optional highlighted cell.
module draw_grid_image #(
  parameter int HRES = 640,
  parameter int VRES = 480,
  parameter int ADDR_W = 18,
  parameter int GRID_N = 4,
  parameter int LINE_W = 2,
  parameter int BASE_ADDR = 16,
  parameter int HDR_W_ADDR = 0,
  parameter int HDR_H_ADDR = 4,
  parameter int MEM_LAT = 1,
  parameter logic [23:0] LINE_RGB = 24'hFF0000,
  parameter logic [23:0] BG_RGB = 24'hFFFFFF
) (
  input logic clk,
  input logic rst,
  draw_grid_image_if.slave bus
);
  localparam int LG = $clog2(GRID_N);
  localparam logic [3:0] LAT = 4'(MEM_LAT);
  localparam logic [3:0] LAST = 4'(GRID_N - 1);
  typedef enum logic [2:0] {RD_WH, RD_WL, RD_HH, RD_HL, CHECK, CALC, DISPLAY} state_t;
  state_t r_state, w_next;
  logic [3:0] r_cnt;
  logic [31:0] r_hdr;
  logic [9:0] r_img_w, r_img_h;
  logic r_hdr_err;
  logic [ADDR_W-1:0] r_addr;
  logic [9:0] r_bx [GRID_N];
  logic [9:0] r_by [GRID_N];
  logic [1:0] r_cls [MEM_LAT+1];
  logic [23:0] r_rgb;
  logic [15:0] w_w, w_h;
  logic [13:0] w_px, w_py;
  logic w_tick, w_line, w_hl;
  logic [2:0] w_cx, w_cy;
  logic [1:0] w_cls;
  assign w_w = r_hdr[31:16];
  assign w_h = r_hdr[15:0];
  assign w_tick = r_cnt == LAT;
  assign w_px = 14'(r_cnt) * 14'(r_img_w);
  assign w_py = 14'(r_cnt) * 14'(r_img_h);
  assign bus.rdaddress = r_addr;
  assign bus.ready = r_state == DISPLAY;
  assign bus.hdr_err = r_hdr_err;
  assign {bus.red, bus.green, bus.blue} = r_rgb;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= RD_WH;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      RD_WH: w_next = w_tick ? RD_WL : RD_WH;
      RD_WL: w_next = w_tick ? RD_HH : RD_WL;
      RD_HH: w_next = w_tick ? RD_HL : RD_HH;
      RD_HL: w_next = w_tick ? CHECK : RD_HL;
      CHECK: w_next = CALC;
      CALC: w_next = r_cnt == LAST ? DISPLAY : CALC;
      DISPLAY: w_next = bus.reload ? RD_WH : DISPLAY;
      default: w_next = RD_WH;
    endcase
  end
  // class: 3 outside image, 2 grid line, 1 highlighted cell, 0 plain pixel
  always_comb begin
    w_line = 1'b0;
    w_cx = '0;
    w_cy = '0;
    for (int k = 1; k < GRID_N; k++) begin
      w_line = w_line | (bus.x >= r_bx[k] && 11'(bus.x) < 11'(r_bx[k]) + 11'(LINE_W))
                      | (bus.y >= r_by[k] && 11'(bus.y) < 11'(r_by[k]) + 11'(LINE_W));
      w_cx = w_cx + 3'(bus.x >= r_bx[k]);
      w_cy = w_cy + 3'(bus.y >= r_by[k]);
    end
    w_hl = bus.hl_en && w_cx == bus.hl_cx && w_cy == bus.hl_cy;
    w_cls = (bus.x >= r_img_w || bus.y >= r_img_h) ? 2'd3 : w_line ? 2'd2 : w_hl ? 2'd1 : 2'd0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt <= '0;
      r_hdr <= '0;
      r_img_w <= '0;
      r_img_h <= '0;
      r_hdr_err <= 1'b0;
      r_addr <= ADDR_W'(HDR_W_ADDR);
      for (int i = 0; i < GRID_N; i++) begin
        r_bx[i] <= '0;
        r_by[i] <= '0;
      end
    end else if (r_state inside {RD_WH, RD_WL, RD_HH, RD_HL}) begin
      r_cnt <= w_tick ? '0 : r_cnt + 4'd1;
      if (w_tick) begin
        r_hdr <= {r_hdr[23:0], bus.q};
        r_addr <= ADDR_W'(r_state == RD_WH ? HDR_W_ADDR + 1 : r_state == RD_WL ? HDR_H_ADDR : HDR_H_ADDR + 1);
      end
    end else if (r_state == CHECK) begin
      r_img_w <= (w_w == '0 || w_w > 16'(HRES)) ? 10'(HRES) : w_w[9:0];
      r_img_h <= (w_h == '0 || w_h > 16'(VRES)) ? 10'(VRES) : w_h[9:0];
      r_hdr_err <= w_w == '0 || w_w > 16'(HRES) || w_h == '0 || w_h > 16'(VRES);
      r_cnt <= 4'd1;
    end else if (r_state == CALC) begin
      r_bx[r_cnt[LG-1:0]] <= 10'(w_px >> LG);
      r_by[r_cnt[LG-1:0]] <= 10'(w_py >> LG);
      r_cnt <= r_cnt + 4'd1;
    end else if (bus.reload) begin
      r_addr <= ADDR_W'(HDR_W_ADDR);
      r_cnt <= '0;
    end else if (bus.x < r_img_w && bus.y < r_img_h)
      r_addr <= ADDR_W'(BASE_ADDR) + ADDR_W'(bus.y) * ADDR_W'(r_img_w) + ADDR_W'(bus.x);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i <= MEM_LAT; i++) r_cls[i] <= '0;
      r_rgb <= '0;
    end else begin
      r_cls[0] <= w_cls;
      for (int i = 1; i <= MEM_LAT; i++) r_cls[i] <= r_cls[i-1];
      r_rgb <= w_next != DISPLAY ? '0 :
               r_cls[MEM_LAT] == 2'd3 ? BG_RGB :
               r_cls[MEM_LAT] == 2'd2 ? LINE_RGB :
               r_cls[MEM_LAT] == 2'd1 ? {bus.q, bus.q, 8'hFF} : {3{bus.q}};
    end
endmodule

// File: tb/tb_draw_grid_image.sv
// tb_draw_grid_image: directed checks of header load, overlay, highlight, reload and read latency
module tb_draw_grid_image;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic [7:0] mem [0:262143];
  logic [7:0] d1 = '0, d2 = '0;
  draw_grid_image_if #(.ADDR_W(18)) b0 ();
  draw_grid_image_if #(.ADDR_W(18)) b1 ();
  draw_grid_image #(.MEM_LAT(1)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  draw_grid_image #(.MEM_LAT(3)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    b0.q <= mem[b0.rdaddress];
    d1 <= mem[b1.rdaddress];
    d2 <= d1;
    b1.q <= d2;
  end

  function automatic logic [23:0] gray(input int x, input int y, input int w);
    logic [17:0] a;
    a = 18'(16 + y * w + x);
    return {3{mem[a]}};
  endfunction

  task automatic set_hdr(input logic [15:0] w, input logic [15:0] h);
    mem[0] = w[15:8];
    mem[1] = w[7:0];
    mem[4] = h[15:8];
    mem[5] = h[7:0];
  endtask

  task automatic wait_ready(input int sel, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sel == 0 ? b0.ready : b1.ready) && n < 100);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++; if (b0.rdaddress !== 18'd0) begin bad++; $display("FAIL reset_addr0: got %0d want 0", b0.rdaddress); end
    total++; if (b0.ready !== 1'b0) begin bad++; $display("FAIL reset_ready0: got %b want 0", b0.ready); end
    total++; if (b0.hdr_err !== 1'b0) begin bad++; $display("FAIL reset_err0: got %b want 0", b0.hdr_err); end
    total++; if ({b0.red, b0.green, b0.blue} !== 24'h0) begin bad++; $display("FAIL reset_rgb0: got %h want 000000", {b0.red, b0.green, b0.blue}); end
    total++; if (b1.rdaddress !== 18'd0) begin bad++; $display("FAIL reset_addr1: got %0d want 0", b1.rdaddress); end
    total++; if (b1.ready !== 1'b0) begin bad++; $display("FAIL reset_ready1: got %b want 0", b1.ready); end
    total++; if ({b1.red, b1.green, b1.blue} !== 24'h0) begin bad++; $display("FAIL reset_rgb1: got %h want 000000", {b1.red, b1.green, b1.blue}); end
  endtask

  task automatic test_header;
    int n;
    rst = 1'b0;
    wait_ready(0, n);
    total++; if (n != 12) begin bad++; $display("FAIL hdr_ready_cycles: got %0d want 12", n); end
    total++; if (b0.hdr_err !== 1'b0) begin bad++; $display("FAIL hdr_err_ok: got %b want 0", b0.hdr_err); end
  endtask

  task automatic test_latency;
    b0.x = 10'd450; b0.y = 10'd10;
    repeat (4) @(negedge clk);
    b0.x = 10'd0; b0.y = 10'd0;
    @(negedge clk);
    total++; if (b0.rdaddress !== 18'd16) begin bad++; $display("FAIL lat_addr00: got %0d want 16", b0.rdaddress); end
    total++; if ({b0.red, b0.green, b0.blue} !== 24'hFFFFFF) begin bad++; $display("FAIL lat_c1: got %h want ffffff", {b0.red, b0.green, b0.blue}); end
    b0.x = 10'd450; b0.y = 10'd10;
    @(negedge clk);
    total++; if ({b0.red, b0.green, b0.blue} !== 24'hFFFFFF) begin bad++; $display("FAIL lat_c2_early: got %h want ffffff", {b0.red, b0.green, b0.blue}); end
    @(negedge clk);
    total++; if ({b0.red, b0.green, b0.blue} !== 24'h5A5A5A) begin bad++; $display("FAIL lat_pix00: got %h want 5a5a5a", {b0.red, b0.green, b0.blue}); end
    @(negedge clk);
    total++; if ({b0.red, b0.green, b0.blue} !== 24'hFFFFFF) begin bad++; $display("FAIL lat_after: got %h want ffffff", {b0.red, b0.green, b0.blue}); end
    b0.x = 10'd3; b0.y = 10'd1;
    @(negedge clk);
    total++; if (b0.rdaddress !== 18'd419) begin bad++; $display("FAIL lat_addr31: got %0d want 419", b0.rdaddress); end
    repeat (2) @(negedge clk);
    total++; if ({b0.red, b0.green, b0.blue} !== gray(3, 1, 400)) begin bad++; $display("FAIL lat_pix31: got %h want %h", {b0.red, b0.green, b0.blue}, gray(3, 1, 400)); end
  endtask

  task automatic test_lines;
    int tx[13] = '{100, 101, 50, 102, 450, 10, 99, 200, 300, 5, 5, 5, 399};
    int ty[13] = '{50, 50, 217, 50, 10, 440, 50, 5, 5, 108, 324, 326, 431};
    int tk[13] = '{1, 1, 1, 0, 2, 2, 0, 1, 1, 1, 1, 0, 0};
    logic [23:0] exp_rgb;
    for (int i = 0; i < 13; i++) begin
      b0.x = 10'(tx[i]); b0.y = 10'(ty[i]);
      repeat (3) @(negedge clk);
      exp_rgb = tk[i] == 2 ? 24'hFFFFFF : tk[i] == 1 ? 24'hFF0000 : gray(tx[i], ty[i], 400);
      total++; if ({b0.red, b0.green, b0.blue} !== exp_rgb) begin bad++; $display("FAIL line_pix(%0d,%0d): got %h want %h", tx[i], ty[i], {b0.red, b0.green, b0.blue}, exp_rgb); end
    end
  endtask

  task automatic test_highlight;
    b0.hl_en = 1'b1; b0.hl_cx = 3'd1; b0.hl_cy = 3'd2;
    b0.x = 10'd150; b0.y = 10'd250;
    repeat (3) @(negedge clk);
    total++; if ({b0.red, b0.green, b0.blue} !== 24'h2020FF) begin bad++; $display("FAIL hl_tint: got %h want 2020ff", {b0.red, b0.green, b0.blue}); end
    b0.x = 10'd250;
    repeat (3) @(negedge clk);
    total++; if ({b0.red, b0.green, b0.blue} !== 24'h202020) begin bad++; $display("FAIL hl_other_cell: got %h want 202020", {b0.red, b0.green, b0.blue}); end
    b0.x = 10'd100;
    repeat (3) @(negedge clk);
    total++; if ({b0.red, b0.green, b0.blue} !== 24'hFF0000) begin bad++; $display("FAIL hl_line_wins: got %h want ff0000", {b0.red, b0.green, b0.blue}); end
    b0.x = 10'd150; b0.hl_cx = 3'd5;
    repeat (3) @(negedge clk);
    total++; if ({b0.red, b0.green, b0.blue} !== 24'h202020) begin bad++; $display("FAIL hl_out_of_range: got %h want 202020", {b0.red, b0.green, b0.blue}); end
    b0.hl_cx = 3'd1; b0.hl_en = 1'b0;
    repeat (3) @(negedge clk);
    total++; if ({b0.red, b0.green, b0.blue} !== 24'h202020) begin bad++; $display("FAIL hl_disabled: got %h want 202020", {b0.red, b0.green, b0.blue}); end
  endtask

  task automatic test_reload_clamp;
    int n;
    int tx[7] = '{160, 162, 480, 5, 5, 639, 5};
    int ty[7] = '{10, 10, 5, 120, 360, 300, 479};
    int tk[7] = '{1, 0, 1, 1, 1, 0, 0};
    logic [23:0] exp_rgb;
    set_hdr(16'd0, 16'd900);
    b0.x = 10'd450; b0.y = 10'd10;
    repeat (3) @(negedge clk);
    total++; if ({b0.red, b0.green, b0.blue} !== 24'hFFFFFF) begin bad++; $display("FAIL reload_pre_rgb: got %h want ffffff", {b0.red, b0.green, b0.blue}); end
    b0.reload = 1'b1;
    @(negedge clk);
    b0.reload = 1'b0;
    total++; if (b0.ready !== 1'b0) begin bad++; $display("FAIL reload_ready: got %b want 0", b0.ready); end
    total++; if ({b0.red, b0.green, b0.blue} !== 24'h0) begin bad++; $display("FAIL reload_rgb: got %h want 000000", {b0.red, b0.green, b0.blue}); end
    wait_ready(0, n);
    total++; if (n != 12) begin bad++; $display("FAIL reload_cycles: got %0d want 12", n); end
    total++; if (b0.hdr_err !== 1'b1) begin bad++; $display("FAIL clamp_err: got %b want 1", b0.hdr_err); end
    for (int i = 0; i < 7; i++) begin
      b0.x = 10'(tx[i]); b0.y = 10'(ty[i]);
      repeat (3) @(negedge clk);
      exp_rgb = tk[i] == 1 ? 24'hFF0000 : gray(tx[i], ty[i], 640);
      total++; if ({b0.red, b0.green, b0.blue} !== exp_rgb) begin bad++; $display("FAIL clamp_pix(%0d,%0d): got %h want %h", tx[i], ty[i], {b0.red, b0.green, b0.blue}, exp_rgb); end
    end
  endtask

  task automatic test_reset_calc;
    int n;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    total++; if (b0.hdr_err !== 1'b1) begin bad++; $display("FAIL calc_err_before: got %b want 1", b0.hdr_err); end
    rst = 1'b1;
    #1;
    total++; if (b0.hdr_err !== 1'b0) begin bad++; $display("FAIL calc_rst_err: got %b want 0", b0.hdr_err); end
    total++; if (b0.rdaddress !== 18'd0) begin bad++; $display("FAIL calc_rst_addr: got %0d want 0", b0.rdaddress); end
    total++; if (b0.ready !== 1'b0) begin bad++; $display("FAIL calc_rst_ready: got %b want 0", b0.ready); end
    total++; if ({b0.red, b0.green, b0.blue} !== 24'h0) begin bad++; $display("FAIL calc_rst_rgb: got %h want 000000", {b0.red, b0.green, b0.blue}); end
    set_hdr(16'd400, 16'd432);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    b0.reload = 1'b1;
    @(negedge clk);
    b0.reload = 1'b0;
    wait_ready(0, n);
    total++; if (n != 10) begin bad++; $display("FAIL reload_ignored_cycles: got %0d want 10", n); end
    total++; if (b0.hdr_err !== 1'b0) begin bad++; $display("FAIL restart_err: got %b want 0", b0.hdr_err); end
  endtask

  task automatic test_lat3;
    int n;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_ready(1, n);
    total++; if (n != 20) begin bad++; $display("FAIL lat3_ready_cycles: got %0d want 20", n); end
    b1.x = 10'd450; b1.y = 10'd10;
    repeat (6) @(negedge clk);
    b1.x = 10'd0; b1.y = 10'd0;
    @(negedge clk);
    total++; if (b1.rdaddress !== 18'd16) begin bad++; $display("FAIL lat3_addr: got %0d want 16", b1.rdaddress); end
    b1.x = 10'd450; b1.y = 10'd10;
    repeat (3) @(negedge clk);
    total++; if ({b1.red, b1.green, b1.blue} !== 24'hFFFFFF) begin bad++; $display("FAIL lat3_early: got %h want ffffff", {b1.red, b1.green, b1.blue}); end
    @(negedge clk);
    total++; if ({b1.red, b1.green, b1.blue} !== 24'h5A5A5A) begin bad++; $display("FAIL lat3_pix00: got %h want 5a5a5a", {b1.red, b1.green, b1.blue}); end
    @(negedge clk);
    total++; if ({b1.red, b1.green, b1.blue} !== 24'hFFFFFF) begin bad++; $display("FAIL lat3_after: got %h want ffffff", {b1.red, b1.green, b1.blue}); end
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) mem[i] = 8'(i ^ (i >> 8));
    set_hdr(16'd400, 16'd432);
    mem[16] = 8'h5A;
    mem[100166] = 8'h20;
    mem[100266] = 8'h20;
    mem[100116] = 8'h20;
    b0.reload = 1'b0; b0.x = '0; b0.y = '0; b0.hl_en = 1'b0; b0.hl_cx = '0; b0.hl_cy = '0;
    b1.reload = 1'b0; b1.x = '0; b1.y = '0; b1.hl_en = 1'b0; b1.hl_cx = '0; b1.hl_cy = '0;
    test_reset;
    test_header;
    test_latency;
    test_lines;
    test_highlight;
    test_reload_clamp;
    test_reset_calc;
    test_lat3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
